// File: rtl/aes_pkg.sv
// Shared AES definitions for the decryption core.
// Contents: key-size (mux) encodings, Nr/Nk lookups, controller state
// enumeration, GF(2^8) arithmetic, the forward and inverse S-box (built from
// the field inverse plus the affine map), the Rcon table and word helpers for
// key expansion.
package aes_pkg;

  localparam logic [1:0] MUX_128 = 2'b00;
  localparam logic [1:0] MUX_192 = 2'b01;
  localparam logic [1:0] MUX_256 = 2'b10;
  localparam logic [1:0] MUX_RSV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYGEN,
    ST_INIT_ARK,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } state_e;

  function automatic logic [3:0] nr_of(input logic [1:0] mux);
    case (mux)
      MUX_192: return 4'd12;
      MUX_256: return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] mux);
    case (mux)
      MUX_192: return 4'd6;
      MUX_256: return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_decrypt_if.sv
// Request/result bundle of the AES decryption core.
// master: drives start/key/mux/in_state, observes results.
// slave : the core; drives out_state/counter/busy/finishDecrypt.
interface aes_decrypt_if;
  logic         start;
  logic [255:0] key;
  logic [1:0]   mux;
  logic [127:0] in_state;
  logic [127:0] out_state;
  logic [3:0]   counter;
  logic         busy;
  logic         finishDecrypt;

  modport master (
    output start, key, mux, in_state,
    input  out_state, counter, busy, finishDecrypt
  );

  modport slave (
    input  start, key, mux, in_state,
    output out_state, counter, busy, finishDecrypt
  );
endinterface

// File: rtl/aes_inv_round.sv
// One combinational inverse AES round.
// state_in  : working state (byte 0 in bits [127:120], column-major)
// round_key : round key to add after InvSubBytes
// mix_en    : apply InvMixColumns (low in the final round)
// state_out : InvMixColumns(InvSubBytes(InvShiftRows(state_in)) ^ round_key)
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         mix_en,
  output logic [127:0] state_out
);
  logic [127:0] ark;
  logic [7:0]   a0, a1, a2, a3;

  always_comb begin
    ark       = '0;
    state_out = '0;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    // Row r rotates right by r: out[r][c] takes in[r][(c - r) mod 4].
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ark[127 - 8*(4*c + r) -: 8] =
          inv_sbox(state_in[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]) ^
          round_key[127 - 8*(4*c + r) -: 8];
      end
    end
    state_out = ark;
    if (mix_en) begin
      for (int c = 0; c < 4; c++) begin
        a0 = ark[127 - 32*c -: 8];
        a1 = ark[119 - 32*c -: 8];
        a2 = ark[111 - 32*c -: 8];
        a3 = ark[103 - 32*c -: 8];
        state_out[127 - 32*c -: 32] = {
          gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
          gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
          gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
          gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
      end
    end
  end
endmodule

// File: rtl/aes_decrypt.sv
// Iterative AES-128/192/256 decryption core.
// clk, reset : clock and synchronous active-high reset
// bus.start/key/mux/in_state : request (mux 00/01/10 = 128/192/256, 11 ignored)
// bus.out_state : working state, plaintext once finishDecrypt is high
// bus.counter   : inverse rounds completed
// bus.busy      : operation in progress
// bus.finishDecrypt : level, high while the result is held
// Flow: expand the key one word per cycle into the round-key store, then
// run the inverse rounds from rk[Nr] down to rk[0].
module aes_decrypt
  import aes_pkg::*;
#(
  parameter int NR_MAX = 14
) (
  input  logic         clk,
  input  logic         reset,
  aes_decrypt_if.slave bus
);
  localparam int RK_WORDS = 4 * (NR_MAX + 1);
  localparam int IW       = $clog2(RK_WORDS);

  state_e        state_q, state_d;
  logic [1:0]    mux_q, mux_d;
  logic [127:0]  out_state_q, out_state_d;
  logic [127:0]  in_state_q, in_state_d;
  logic [3:0]    counter_q, counter_d;
  logic          busy_q, busy_d;
  logic          finish_q, finish_d;
  logic [IW-1:0] kidx_q, kidx_d;
  logic [2:0]    kpos_q, kpos_d;
  logic [3:0]    rcon_idx_q, rcon_idx_d;
  logic [3:0]    rnd_q, rnd_d;
  logic          accept, kg_we, mix_en;
  logic [3:0]    nr_sel, nk_sel;
  logic [31:0]   rk_mem [RK_WORDS];
  logic [IW-1:0] rk_base;
  logic [127:0]  rk_cur, round_out;
  logic [31:0]   w_prev, w_back, w_temp, w_new;

  assign nr_sel  = nr_of(mux_q);
  assign nk_sel  = nk_of(mux_q);
  assign rk_base = IW'({rnd_q, 2'b00});
  assign rk_cur  = {rk_mem[rk_base], rk_mem[rk_base + IW'(1)],
                    rk_mem[rk_base + IW'(2)], rk_mem[rk_base + IW'(3)]};
  assign mix_en  = (state_q == ST_ROUND);

  aes_inv_round u_inv_round (
    .state_in  (out_state_q),
    .round_key (rk_cur),
    .mix_en    (mix_en),
    .state_out (round_out)
  );

  // Key expansion: w[i] = w[i-Nk] ^ f(w[i-1]); kpos_q tracks i mod Nk.
  always_comb begin
    w_prev = rk_mem[kidx_q - IW'(1)];
    w_back = rk_mem[kidx_q - IW'(nk_sel)];
    w_temp = w_prev;
    if (kpos_q == 3'd0) begin
      w_temp = sub_word(rot_word(w_prev)) ^ {rcon(rcon_idx_q), 24'h0};
    end else if (nk_sel == 4'd8 && kpos_q == 3'd4) begin
      w_temp = sub_word(w_prev);
    end
    w_new = w_back ^ w_temp;
  end

  always_comb begin
    state_d     = state_q;
    mux_d       = mux_q;
    out_state_d = out_state_q;
    in_state_d  = in_state_q;
    counter_d   = counter_q;
    busy_d      = busy_q;
    finish_d    = finish_q;
    kidx_d      = kidx_q;
    kpos_d      = kpos_q;
    rcon_idx_d  = rcon_idx_q;
    rnd_d       = rnd_q;
    accept      = 1'b0;
    kg_we       = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start && bus.mux != MUX_RSV) begin
          accept     = 1'b1;
          state_d    = ST_KEYGEN;
          mux_d      = bus.mux;
          in_state_d = bus.in_state;
          kidx_d     = IW'(nk_of(bus.mux));
          kpos_d     = 3'd0;
          rcon_idx_d = 4'd1;
          counter_d  = 4'd0;
          finish_d   = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_KEYGEN: begin
        kg_we  = 1'b1;
        kidx_d = kidx_q + IW'(1);
        kpos_d = ({1'b0, kpos_q} == nk_sel - 4'd1) ? 3'd0 : kpos_q + 3'd1;
        if (kpos_q == 3'd0) rcon_idx_d = rcon_idx_q + 4'd1;
        // Last word is index 4*Nr+3 = 4*(Nr+1)-1.
        if (kidx_q == IW'({nr_sel, 2'b11})) begin
          state_d = ST_INIT_ARK;
          rnd_d   = nr_sel;
        end
      end
      ST_INIT_ARK: begin
        out_state_d = in_state_q ^ rk_cur;
        rnd_d       = rnd_q - 4'd1;
        state_d     = ST_ROUND;
      end
      ST_ROUND: begin
        out_state_d = round_out;
        counter_d   = counter_q + 4'd1;
        rnd_d       = rnd_q - 4'd1;
        if (rnd_q == 4'd1) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        out_state_d = round_out;
        counter_d   = nr_sel;
        busy_d      = 1'b0;
        finish_d    = 1'b1;
        state_d     = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and visible outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mux_q       <= MUX_128;
      out_state_q <= '0;
      counter_q   <= '0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
      kidx_q      <= '0;
      kpos_q      <= '0;
      rcon_idx_q  <= '0;
      rnd_q       <= '0;
    end else begin
      state_q     <= state_d;
      mux_q       <= mux_d;
      out_state_q <= out_state_d;
      counter_q   <= counter_d;
      busy_q      <= busy_d;
      finish_q    <= finish_d;
      kidx_q      <= kidx_d;
      kpos_q      <= kpos_d;
      rcon_idx_q  <= rcon_idx_d;
      rnd_q       <= rnd_d;
    end
  end

  // Latched ciphertext and round-key store; always written before being read.
  always_ff @(posedge clk) begin
    in_state_q <= in_state_d;
    if (accept && !reset) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < nk_of(bus.mux)) rk_mem[IW'(i)] <= bus.key[255 - 32*i -: 32];
      end
    end else if (kg_we && !reset) begin
      rk_mem[kidx_q] <= w_new;
    end
  end

  assign bus.out_state     = out_state_q;
  assign bus.counter       = counter_q;
  assign bus.busy          = busy_q;
  assign bus.finishDecrypt = finish_q;
endmodule

// File: doc/aes_decrypt.md
AES_DECRYPT -- requirements
Module: aes_decrypt

Interface
REQ-001 SHALL have parameter NR_MAX, default 14, giving the maximum round count and sizing the round-key store.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, a one-cycle request to decrypt in_state.
REQ-005 SHALL have port key, input, 256, the cipher key, left-aligned: AES-128 uses key[255:128], AES-192 uses key[255:64], AES-256 uses key[255:0].
REQ-006 SHALL have port mux, input, 2, key-size select: 00=128, 01=192, 10=256, 11=reserved.
REQ-007 SHALL have port in_state, input, 128, the ciphertext block.
REQ-008 SHALL have port out_state, output, 128, the working state, holding plaintext when finished.
REQ-009 SHALL have port counter, output, 4, the number of inverse rounds completed.
REQ-010 SHALL have port busy, output, 1, high from the accepting edge until entry to DONE.
REQ-011 SHALL have port finishDecrypt, output, 1, a level that is high while in DONE.

Function
REQ-012 SHALL use states IDLE, KEYGEN, INIT_ARK, ROUND, FINAL and DONE, with Nr=10/12/14 and Nk=4/6/8 set by mux.
REQ-013 SHALL accept start only in IDLE or DONE with mux!=11; on acceptance it SHALL latch key, mux and in_state, load the first Nk words of the key schedule, clear counter and finishDecrypt, set busy, and go to KEYGEN.
REQ-014 SHALL ignore start when mux=11, or while busy, with no change to any state or output.
REQ-015 In KEYGEN, SHALL produce one key-schedule word w[i] per cycle using the FIPS-197 recurrence (RotWord/SubWord/Rcon; extra SubWord at i mod 8 = 4 for Nk=8), for G=4(Nr+1)-Nk cycles (40/46/52).
REQ-016 In INIT_ARK (1 cycle), SHALL set out_state = latched in_state XOR rk[Nr].
REQ-017 In ROUND, one cycle per r = Nr-1 down to 1, SHALL set out_state = InvMixColumns(InvSubBytes(InvShiftRows(out_state)) XOR rk[r]) and increment counter.
REQ-018 In FINAL (1 cycle), SHALL set out_state = InvSubBytes(InvShiftRows(out_state)) XOR rk[0], set counter=Nr, clear busy, set finishDecrypt, and go to DONE.
REQ-019 SHALL have latency from the accepting edge to the edge that sets finishDecrypt of G+Nr+1 cycles: 51 for AES-128, 59 for AES-192, 67 for AES-256.
REQ-020 In DONE, SHALL hold out_state, counter and finishDecrypt stable until the next accepted start.
REQ-021 SHALL use the mux value latched at start for the whole operation; mux changes mid-operation have no effect.
REQ-022 SHALL keep the round-key store at 4(NR_MAX+1) 32-bit words; indices beyond 4(Nr+1)-1 are never written or read for the selected key size.

Reset
REQ-023 On reset, SHALL synchronously enter IDLE and set out_state=0, counter=0, busy=0 and finishDecrypt=0, including mid-operation.
REQ-024 If reset and start are both high on the same edge, reset SHALL win and start SHALL be dropped.
REQ-025 The round-key store SHALL need no reset; it is written fully before any read.

Structure
REQ-026 Shared package aes_pkg SHALL hold the forward and inverse S-box functions, the Rcon table, the mux encodings, the Nr/Nk lookup functions, and the state enumeration.
REQ-027 A single combinational sub-module, aes_inv_round, SHALL implement InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns; InvMixColumns is bypassed by a select input used in FINAL.
REQ-028 Key expansion SHALL stay inside aes_decrypt.

Verification
REQ-029 mux=00, key[255:128]=000102030405060708090a0b0c0d0e0f, in_state=69c4e0d86a7b0430d8cdb78070b4c55a -> out_state=00112233445566778899aabbccddeeff, finishDecrypt 51 cycles after start, counter=10.
REQ-030 mux=01, key[255:64]=000102...1617, in_state=dda97ca4864cdfe06eaf70a0ec0d7191 -> out_state=00112233445566778899aabbccddeeff after 59 cycles, counter=12.
REQ-031 mux=10, key=000102...1e1f, in_state=8ea2b7ca516745bfeafc49904b496089 -> out_state=00112233445566778899aabbccddeeff after 67 cycles, counter=14.
REQ-032 Start pulsed again at cycle 5 and cycle 30 of an AES-128 run -> both ignored, result and latency identical to REQ-029.
REQ-033 Reset asserted at cycle 45 of an AES-256 run -> all outputs 0 next cycle; a following AES-128 start yields the REQ-029 result.
REQ-034 mux=11 with a start pulse -> busy stays 0, state stays IDLE and outputs are unchanged.
